// File: rtl/tile_ctrl_pkg.sv
// Shared encodings for the MAC tile array control path: c3 codes, beat tags,
// and sequencer states.
package tile_ctrl_pkg;

  typedef enum logic [1:0] {
    C3_ZERO = 2'b00,
    C3_IP1  = 2'b01,
    C3_IP2  = 2'b10,
    C3_ACC  = 2'b11
  } c3_code_t;

  // FIRST is the all-zero code so a cleared tag pipeline shows c3 = 00
  typedef enum logic [1:0] {
    TAG_FIRST = 2'd0,
    TAG_ACC   = 2'd1,
    TAG_HOLD  = 2'd2
  } tag_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_UNLOAD = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic c3_code_t tag_to_c3(input tag_t t);
    return (t == TAG_FIRST) ? C3_ZERO : C3_ACC;
  endfunction

endpackage

// File: rtl/tile_tag_shift.sv
// Per-tile beat tag pipeline: stage k holds the tag issued k+1 edges ago and
// is decoded into tile k's accumulator select.
module tile_tag_shift
  import tile_ctrl_pkg::*;
#(
  parameter int unsigned NUM_TILES = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clr,
  input  tag_t                     tag_in,
  output logic [2*NUM_TILES-1:0]   c3
);

  tag_t stage [NUM_TILES];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < NUM_TILES; k++) stage[k] <= TAG_FIRST;
    end else if (clr) begin
      for (int k = 0; k < NUM_TILES; k++) stage[k] <= TAG_FIRST;
    end else begin
      stage[0] <= tag_in;
      for (int k = 1; k < NUM_TILES; k++) stage[k] <= stage[k-1];
    end
  end

  always_comb begin
    c3 = '0;
    for (int k = 0; k < NUM_TILES; k++) c3[2*k +: 2] = tag_to_c3(stage[k]);
  end

endmodule

// File: rtl/tile_array_sequencer.sv
// Job sequencer for a chain of MAC tiles: load operand beats, drain the
// operand pipeline, then unload every accumulator through the OP1 chain.
module tile_array_sequencer
  import tile_ctrl_pkg::*;
#(
  parameter int unsigned NUM_TILES = 4,
  parameter int unsigned LEN_W     = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     feed_en,
  output logic [NUM_TILES-1:0]     c1,
  output logic [NUM_TILES-1:0]     c2,
  output logic [2*NUM_TILES-1:0]   c3,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned CNT_W = $clog2(2*NUM_TILES);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(NUM_TILES - 1);
  localparam logic [CNT_W-1:0] UNLOAD_LAST = CNT_W'(2*NUM_TILES - 2);
  localparam logic [CNT_W-1:0] OUT_FIRST   = CNT_W'(NUM_TILES - 1);

  state_t               state, state_d;
  logic [LEN_W-1:0]     beats_left, beats_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic                 accept;
  tag_t                 tag_in;
  logic                 tag_clr;
  logic                 in_ready_d, out_valid_d, busy_d, done_d;
  logic [NUM_TILES-1:0] c1_d;

  assign accept  = in_ready & in_valid;
  assign feed_en = accept;
  assign c2      = '0;

  // State, counters and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      beats_left <= '0;
      len_q      <= '0;
      cnt        <= '0;
      in_ready   <= 1'b0;
      c1         <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      beats_left <= beats_d;
      len_q      <= len_d;
      cnt        <= cnt_d;
      in_ready   <= in_ready_d;
      c1         <= c1_d;
      out_valid  <= out_valid_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Next state; cnt is the drain cycle in DRAIN and the unload index j in UNLOAD
  always_comb begin
    state_d = state;
    beats_d = beats_left;
    len_d   = len_q;
    cnt_d   = cnt;
    unique case (state)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          if (len != '0) begin
            len_d   = len;
            beats_d = len;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          beats_d = beats_left - LEN_W'(1);
          if (beats_left == LEN_W'(1)) begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_d = ST_UNLOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_UNLOAD: begin
        if (cnt == UNLOAD_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode of the next state so every output lands on a flop
  always_comb begin
    in_ready_d  = (state_d == ST_LOAD);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    out_valid_d = (state_d == ST_UNLOAD) && (cnt_d >= OUT_FIRST);
    c1_d        = '0;
    for (int k = 0; k < NUM_TILES; k++)
      c1_d[k] = (state_d == ST_UNLOAD) && (cnt_d == CNT_W'(2*k));
    tag_clr = (state_d == ST_IDLE);
    tag_in  = TAG_HOLD;
    if (accept) tag_in = (beats_left == len_q) ? TAG_FIRST : TAG_ACC;
  end

  tile_tag_shift #(
    .NUM_TILES (NUM_TILES)
  ) u_tag_shift (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (tag_clr),
    .tag_in (tag_in),
    .c3     (c3)
  );

endmodule

// File: tb/tb_tile_array_sequencer.sv
// Directed bench for tile_array_sequencer with a small behavioural MAC tile
// chain driven by the sequencer's controls.
module tb_tile_array_sequencer;

  localparam int N  = 4;
  localparam int LW = 8;

  logic            CLK = 1'b0;
  logic            RST;
  logic            start;
  logic [LW-1:0]   len;
  logic            in_valid;
  logic            in_ready;
  logic            feed_en;
  logic [N-1:0]    c1;
  logic [N-1:0]    c2;
  logic [2*N-1:0]  c3;
  logic            out_valid;
  logic            busy;
  logic            done;
  logic [31:0]     a_in, b_in;

  int n_total = 0;
  int n_bad   = 0;

  tile_array_sequencer #(.NUM_TILES(N), .LEN_W(LW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .feed_en   (feed_en),
    .c1        (c1),
    .c2        (c2),
    .c3        (c3),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  // Tile chain: operands hop one tile per cycle, OP1 forwards toward the last tile
  logic [31:0] pa [N];
  logic [31:0] pb [N];
  logic [31:0] acc [N];
  logic [31:0] fwd [N];
  logic [31:0] op1 [N];

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < N; k++) begin
        pa[k] <= '0; pb[k] <= '0; acc[k] <= '0; fwd[k] <= '0;
      end
    end else begin
      pa[0]  <= feed_en ? a_in : 32'd0;
      pb[0]  <= feed_en ? b_in : 32'd0;
      fwd[0] <= '0;
      for (int k = 1; k < N; k++) begin
        pa[k]  <= pa[k-1];
        pb[k]  <= pb[k-1];
        fwd[k] <= op1[k-1];
      end
      for (int k = 0; k < N; k++) begin
        case (c3[2*k +: 2])
          2'b00:   acc[k] <= pa[k] * pb[k];
          2'b11:   acc[k] <= acc[k] + pa[k] * pb[k];
          default: acc[k] <= 32'hDEAD_BEEF;
        endcase
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) op1[k] = c1[k] ? acc[k] : fwd[k];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One job from the start edge; bub is the LOAD cycle held as a bubble (-1: none)
  task automatic run_job(input string nm, input int L, input int bub, input bit poke);
    int lp, exp_done, acc_n, done_at, n_done, n_ov;
    int c1_err, ov_err, res_err, misc_err;
    logic [31:0]  exp_res;
    logic [N-1:0] exp_c1;
    logic         exp_ov;
    logic [2*N-1:0] c3_s1, c3_s2;
    lp       = L + ((bub >= 0 && bub < L) ? 1 : 0);
    exp_done = (L == 0) ? 0 : lp + 3*N - 1;
    exp_res  = '0;
    for (int i = 0; i < L; i++) exp_res += 32'((i + 1) * (i + 4));
    acc_n = 0; done_at = -1; n_done = 0; n_ov = 0;
    c1_err = 0; ov_err = 0; res_err = 0; misc_err = 0;
    c3_s1 = '0; c3_s2 = '0;
    start = 1'b1; len = LW'(L); in_valid = 1'b0;
    a_in = 32'd1; b_in = 32'd4;
    step();
    start = 1'b0; len = LW'(77);
    for (int cyc = 0; cyc <= exp_done + 4; cyc++) begin
      if (feed_en !== (in_valid & in_ready)) misc_err++;
      if (in_ready !== (L > 0 && cyc < lp)) misc_err++;
      if (busy !== (cyc <= exp_done)) misc_err++;
      if (c2 !== '0) misc_err++;
      if (done === 1'b1) begin
        n_done++;
        if (done_at < 0) done_at = cyc;
      end
      for (int k = 0; k < N; k++) exp_c1[k] = (L > 0 && cyc == lp + N + 2*k);
      if (c1 !== exp_c1) c1_err++;
      exp_ov = (L > 0 && cyc >= lp + 2*N - 1 && cyc <= lp + 3*N - 2);
      if (out_valid !== exp_ov) ov_err++;
      if (out_valid === 1'b1) begin
        n_ov++;
        if (op1[N-1] !== exp_res) res_err++;
      end
      if (L > 0 && cyc >= lp + N && cyc <= lp + 3*N - 2 && c3 !== '1) misc_err++;
      if (cyc > exp_done && c3 !== '0) misc_err++;
      if (cyc == 1) c3_s1 = c3;
      if (cyc == 2) c3_s2 = c3;
      in_valid = (cyc != bub);
      a_in = 32'(acc_n + 1);
      b_in = 32'(acc_n + 4);
      if (in_valid && in_ready) acc_n++;
      start = poke && (cyc == 1 || cyc == lp + N + 3);
      step();
    end
    start = 1'b0; in_valid = 1'b0;
    check({nm, "_accepts"}, 32'(acc_n), 32'(L));
    check({nm, "_done_cycle"}, 32'(done_at), 32'(exp_done));
    check({nm, "_done_count"}, 32'(n_done), 32'd1);
    check({nm, "_ov_count"}, 32'(n_ov), (L > 0) ? 32'(N) : 32'd0);
    check({nm, "_c1_errs"}, 32'(c1_err), 32'd0);
    check({nm, "_ov_errs"}, 32'(ov_err), 32'd0);
    check({nm, "_result_errs"}, 32'(res_err), 32'd0);
    check({nm, "_ctrl_errs"}, 32'(misc_err), 32'd0);
    if (L > 0) check({nm, "_c3_first"}, 32'(c3_s1[1:0]), 32'd0);
    if (L > 1) check({nm, "_c3_second"}, 32'(c3_s2[1:0]), 32'd3);
  endtask

  initial begin
    int d;
    RST = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    a_in = '0; b_in = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", 32'({in_ready, feed_en, c1, c2, c3, out_valid, busy, done}), 32'd0);
    RST = 1'b0;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    run_job("basic", 3, -1, 1'b0);
    run_job("bubble", 3, 1, 1'b0);
    run_job("len0", 0, -1, 1'b0);
    run_job("poke", 3, -1, 1'b1);

    // Reset in the middle of DRAIN abandons the job
    start = 1'b1; len = LW'(3); a_in = 32'd1; b_in = 32'd4;
    step();
    start = 1'b0; in_valid = 1'b1;
    repeat (5) step();
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("rst_async_outputs", 32'({in_ready, feed_en, c1, c2, c3, out_valid, busy, done}), 32'd0);
    d = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) d++;
    end
    check("rst_held_quiet", 32'(d), 32'd0);
    RST = 1'b0; in_valid = 1'b0;
    step();
    run_job("after_rst", 3, -1, 1'b0);
    run_job("len255", 255, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
